ff_sample_sequencer: RTL and testbench
======================================

FF_SAMPLE_SEQUENCER -- requirements
Module: ff_sample_sequencer

Interface
REQ-001 Parameter ADDR_W, default 12, SHALL set the AER address width.
REQ-002 Parameter GOOD_W, default 32, SHALL set the goodness width.
REQ-003 Parameter TMO_W, default 20, SHALL set the done-timeout counter width.
REQ-004 Port CLK, input, 1: SHALL be the single clock; all logic is rising-edge.
REQ-005 Port RST_N, input, 1: SHALL be the asynchronous, active-low reset.
REQ-006 Port START, input, 1: SHALL be the sample start pulse, honoured only in IDLE.
REQ-007 Ports START_IS_POS and START_IS_TRAIN, inputs, 1 each: SHALL be the pass polarity and mode, sampled with START.
REQ-008 Ports EV_VALID / EV_ADDR[ADDR_W] / EV_LAST, inputs: SHALL be the event stream.
- EV_LAST marks the final event of the sample.
REQ-009 Port EV_READY, output, 1: SHALL be the event-stream accept; a transfer occurs on a cycle where EV_VALID and EV_READY are both 1.
REQ-010 Ports AERIN_ADDR[ADDR_W] / AERIN_REQ, outputs, and AERIN_ACK, input: SHALL form the 4-phase AER link to the core.
REQ-011 Ports IS_POS and IS_TRAIN, outputs, 1 each: SHALL be the core mode lines.
REQ-012 Port PROCESS_DONE, input, 1: SHALL be the core's sample-finished flag.
REQ-013 Port GOODNESS[GOOD_W], input: SHALL be the core's goodness value.
REQ-014 Port TMO_LIMIT[TMO_W], input: SHALL be the done-timeout in cycles.
REQ-015 Outputs BUSY, RESULT_VALID, RESULT_GOODNESS[GOOD_W], RESULT_IS_POS, TMO_ERR and EV_COUNT[16] SHALL report status and results.

Function
REQ-016 The FSM SHALL have the states IDLE, FETCH, REQ_HI, REQ_LO, WAIT_DONE and RESULT.
REQ-017 IDLE + START SHALL latch IS_POS/IS_TRAIN, clear EV_COUNT, RESULT_VALID and TMO_ERR, and go to FETCH.
- IS_POS/IS_TRAIN are held constant until the next START.
REQ-018 FETCH SHALL assert EV_READY.
- On a transfer: register EV_ADDR into AERIN_ADDR, save EV_LAST, go to REQ_HI.
- EV_READY SHALL be 0 in every other state.
REQ-019 REQ_HI SHALL drive AERIN_REQ=1 until synchronised ACK=1, then go to REQ_LO.
REQ-020 REQ_LO SHALL drive AERIN_REQ=0 until synchronised ACK=0, then increment EV_COUNT.
- Next state: WAIT_DONE if the saved LAST=1, else FETCH.
REQ-021 AERIN_ADDR SHALL remain stable from REQ_HI entry until REQ_LO exit.
REQ-022 AERIN_ACK and PROCESS_DONE SHALL each pass through a 2-flop synchroniser, giving 2 cycles of added latency.
REQ-023 WAIT_DONE SHALL count cycles from 0.
- On synchronised DONE=1: capture GOODNESS into RESULT_GOODNESS and IS_POS into RESULT_IS_POS, then go to RESULT.
- If the count equals TMO_LIMIT first: set TMO_ERR=1, leave RESULT_GOODNESS unchanged, then go to RESULT.
REQ-024 If DONE and the timeout occur in the same cycle, DONE SHALL win.
REQ-025 RESULT SHALL pulse RESULT_VALID for exactly 1 cycle, then go to IDLE.
- RESULT_GOODNESS, RESULT_IS_POS and TMO_ERR hold until the next START.
REQ-026 BUSY SHALL be 1 in every state except IDLE.
REQ-027 START outside IDLE SHALL be ignored.
REQ-028 EV_COUNT SHALL saturate at 16'hFFFF.
REQ-029 TMO_LIMIT=0 SHALL time out on the first WAIT_DONE cycle unless DONE is already high in that cycle.
REQ-030 EV_LAST on the first event SHALL yield a one-event sample.

Reset
REQ-031 RST_N=0 SHALL asynchronously force:
- state IDLE;
- all outputs 0 (AERIN_REQ, AERIN_ADDR, EV_READY, IS_POS, IS_TRAIN, BUSY, RESULT_VALID, RESULT_GOODNESS, RESULT_IS_POS, TMO_ERR, EV_COUNT);
- both synchroniser chains and the timeout counter to 0.
REQ-032 Reset mid-handshake SHALL drop AERIN_REQ within the reset assertion, with no glitch after release.

Structure
REQ-033 A shared package SHALL hold:
- the FSM state enumeration;
- the ADDR_W, GOOD_W and TMO_W defaults;
- the EV_COUNT width constant.
REQ-034 The 2-flop synchroniser SHALL be the one sub-module, sync_2ff, instantiated twice.

Verification
REQ-035 START(pos=1, train=1), 3 events 0x005/0x123/0x30F (last on 3rd), core ACKs after 2 cycles, DONE 10 cycles later with GOODNESS=0x0000_0ABC:
- AERIN_ADDR sequence exact;
- EV_COUNT=3;
- RESULT_VALID is a 1-cycle pulse with RESULT_GOODNESS=0x0ABC, RESULT_IS_POS=1, TMO_ERR=0.
REQ-036 ACK withheld 50 cycles on event 0x0AA:
- AERIN_REQ stays 1;
- AERIN_ADDR stays 0x0AA;
- EV_READY stays 0 throughout.
REQ-037 TMO_LIMIT=100, DONE never asserted:
- TMO_ERR=1 and RESULT_VALID pulse at timeout;
- RESULT_GOODNESS retains its prior value;
- BUSY=0 afterwards.
REQ-038 DONE synchronised output and timeout in the same cycle: RESULT_GOODNESS captured and TMO_ERR=0.
REQ-039 RST_N low during REQ_HI: outputs 0 immediately; after release a new START runs a clean 1-event sample (single event with EV_LAST=1) to completion.
REQ-040 START pulsed during WAIT_DONE: ignored; IS_POS unchanged; EV_COUNT not cleared.

Source files
------------

// File: rtl/ff_sample_sequencer_pkg.sv
// Shared types and defaults for the feed-forward sample sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ff_sample_sequencer_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int GOOD_W_DEF = 32;
    localparam int TMO_W_DEF  = 20;
    localparam int EV_COUNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_REQ_HI,
        ST_REQ_LO,
        ST_WAIT_DONE,
        ST_RESULT
    } state_t;

    // Event counter sticks at all-ones instead of wrapping.
    function automatic logic [EV_COUNT_W-1:0] sat_inc(input logic [EV_COUNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
// Latency: 2 clk cycles from input change to q.
// Backpressure: none; level is sampled every cycle.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ff_sample_sequencer.sv
// Streams one sample's AER events into the core over a 4-phase link, then waits for its goodness.
// Latency: 1 cycle accept, 2-cycle synchronised ACK/DONE, result 1 cycle after DONE or timeout.
// Backpressure: ev_ready is only high in FETCH; one event is in flight on the link at a time.
module ff_sample_sequencer
    import ff_sample_sequencer_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int GOOD_W = GOOD_W_DEF,
    parameter int TMO_W  = TMO_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  start_is_pos,
    input  logic                  start_is_train,
    input  logic                  ev_valid,
    input  logic [ADDR_W-1:0]     ev_addr,
    input  logic                  ev_last,
    output logic                  ev_ready,
    output logic [ADDR_W-1:0]     aerin_addr,
    output logic                  aerin_req,
    input  logic                  aerin_ack,
    output logic                  is_pos,
    output logic                  is_train,
    input  logic                  process_done,
    input  logic [GOOD_W-1:0]     goodness,
    input  logic [TMO_W-1:0]      tmo_limit,
    output logic                  busy,
    output logic                  result_valid,
    output logic [GOOD_W-1:0]     result_goodness,
    output logic                  result_is_pos,
    output logic                  tmo_err,
    output logic [EV_COUNT_W-1:0] ev_count
);

    state_t           state;
    state_t           state_nxt;
    logic             ack_s;
    logic             done_s;
    logic             last_q;
    logic [TMO_W-1:0] tmo_cnt;

    logic start_go;
    logic xfer;
    logic cnt_inc;
    logic capture;
    logic timeout;

    sync_2ff u_sync_ack (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (aerin_ack),
        .q     (ack_s)
    );

    sync_2ff u_sync_done (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (process_done),
        .q     (done_s)
    );

    always_comb begin
        state_nxt = state;
        start_go  = 1'b0;
        xfer      = 1'b0;
        cnt_inc   = 1'b0;
        capture   = 1'b0;
        timeout   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    start_go  = 1'b1;
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (ev_valid && ev_ready) begin
                    xfer      = 1'b1;
                    state_nxt = ST_REQ_HI;
                end
            end
            ST_REQ_HI: begin
                if (ack_s) begin
                    state_nxt = ST_REQ_LO;
                end
            end
            ST_REQ_LO: begin
                if (!ack_s) begin
                    cnt_inc   = 1'b1;
                    state_nxt = last_q ? ST_WAIT_DONE : ST_FETCH;
                end
            end
            ST_WAIT_DONE: begin
                // DONE is checked first so it wins a tie with the timeout.
                if (done_s) begin
                    capture   = 1'b1;
                    state_nxt = ST_RESULT;
                end else if (tmo_cnt == tmo_limit) begin
                    timeout   = 1'b1;
                    state_nxt = ST_RESULT;
                end
            end
            ST_RESULT: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Link and status outputs are registered copies of the next-state decode, so they
    // track the state exactly while staying glitch-free on the wire to the core.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            ev_ready        <= 1'b0;
            aerin_req       <= 1'b0;
            aerin_addr      <= '0;
            last_q          <= 1'b0;
            busy            <= 1'b0;
            result_valid    <= 1'b0;
            is_pos          <= 1'b0;
            is_train        <= 1'b0;
            ev_count        <= '0;
            tmo_cnt         <= '0;
            tmo_err         <= 1'b0;
            result_goodness <= '0;
            result_is_pos   <= 1'b0;
        end else begin
            state        <= state_nxt;
            ev_ready     <= (state_nxt == ST_FETCH);
            aerin_req    <= (state_nxt == ST_REQ_HI);
            busy         <= (state_nxt != ST_IDLE);
            result_valid <= (state_nxt == ST_RESULT);

            if (start_go) begin
                is_pos   <= start_is_pos;
                is_train <= start_is_train;
                ev_count <= '0;
                tmo_err  <= 1'b0;
            end

            if (xfer) begin
                aerin_addr <= ev_addr;
                last_q     <= ev_last;
            end

            if (cnt_inc) begin
                ev_count <= sat_inc(ev_count);
            end

            if ((state == ST_WAIT_DONE) && (state_nxt == ST_WAIT_DONE)) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end else begin
                tmo_cnt <= '0;
            end

            if (capture) begin
                result_goodness <= goodness;
                result_is_pos   <= is_pos;
            end

            if (timeout) begin
                tmo_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ff_sample_sequencer.sv
// Bench for ff_sample_sequencer: acts as event source and as the AER core.
// Latency: n/a.
// Backpressure: source holds ev_valid until ev_ready is seen.
module tb_ff_sample_sequencer;
    import ff_sample_sequencer_pkg::*;

    localparam int ADDR_W = 12;
    localparam int GOOD_W = 32;
    localparam int TMO_W  = 20;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  start;
    logic                  start_is_pos;
    logic                  start_is_train;
    logic                  ev_valid;
    logic [ADDR_W-1:0]     ev_addr;
    logic                  ev_last;
    logic                  ev_ready;
    logic [ADDR_W-1:0]     aerin_addr;
    logic                  aerin_req;
    logic                  aerin_ack;
    logic                  is_pos;
    logic                  is_train;
    logic                  process_done;
    logic [GOOD_W-1:0]     goodness;
    logic [TMO_W-1:0]      tmo_limit;
    logic                  busy;
    logic                  result_valid;
    logic [GOOD_W-1:0]     result_goodness;
    logic                  result_is_pos;
    logic                  tmo_err;
    logic [EV_COUNT_W-1:0] ev_count;

    int               vectors    = 0;
    int               miscompares = 0;
    logic [ADDR_W-1:0] seen_addr[$];
    int               ack_dly    = -1;
    bit               ack_stall  = 1'b0;
    logic [GOOD_W-1:0] exp_good  = '0;

    always #5 clk = ~clk;

    ff_sample_sequencer #(.ADDR_W(ADDR_W), .GOOD_W(GOOD_W), .TMO_W(TMO_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .start_is_pos    (start_is_pos),
        .start_is_train  (start_is_train),
        .ev_valid        (ev_valid),
        .ev_addr         (ev_addr),
        .ev_last         (ev_last),
        .ev_ready        (ev_ready),
        .aerin_addr      (aerin_addr),
        .aerin_req       (aerin_req),
        .aerin_ack       (aerin_ack),
        .is_pos          (is_pos),
        .is_train        (is_train),
        .process_done    (process_done),
        .goodness        (goodness),
        .tmo_limit       (tmo_limit),
        .busy            (busy),
        .result_valid    (result_valid),
        .result_goodness (result_goodness),
        .result_is_pos   (result_is_pos),
        .tmo_err         (tmo_err),
        .ev_count        (ev_count)
    );

    // Core side of the 4-phase link: logs each address when REQ rises, ACKs after a delay.
    initial begin
        int d;
        aerin_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && aerin_req && !aerin_ack) begin
                seen_addr.push_back(aerin_addr);
                d = (ack_dly < 0) ? int'($urandom_range(0, 3)) : ack_dly;
                repeat (d) @(negedge clk);
                while (ack_stall) @(negedge clk);
                aerin_ack = 1'b1;
            end else if (!aerin_req && aerin_ack) begin
                d = (ack_dly < 0) ? int'($urandom_range(0, 3)) : ack_dly;
                repeat (d) @(negedge clk);
                aerin_ack = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_start(input logic pos, input logic train);
        @(negedge clk);
        start = 1'b1;
        start_is_pos = pos;
        start_is_train = train;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_events(input int n, input logic [ADDR_W-1:0] a [16], input bit gaps,
                               output bit ok);
        int w;
        ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            w = 0;
            ev_valid = 1'b1;
            ev_addr  = a[i];
            ev_last  = (i == n - 1);
            while (!ev_ready && w < 300) begin
                @(negedge clk);
                w++;
            end
            if (!ev_ready) begin
                ev_valid = 1'b0;
                ok = 1'b0;
                return;
            end
            @(negedge clk);
            ev_valid = 1'b0;
            ev_last  = 1'b0;
            ev_addr  = 12'($urandom);
            if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    task automatic wait_hs(input int n, output bit ok);
        ok = 1'b0;
        for (int w = 0; w < 400; w++) begin
            if (seen_addr.size() == n && !aerin_req && !aerin_ack) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic get_result(input int budget, output bit got, output int cyc,
                              output logic [GOOD_W-1:0] g, output logic p, output logic e,
                              output logic second);
        got = 1'b0;
        cyc = 0;
        g = '0; p = 1'b0; e = 1'b0; second = 1'b0;
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (result_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (got) begin
            g = result_goodness;
            p = result_is_pos;
            e = tmo_err;
            @(negedge clk);
            second = result_valid;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0; start_is_pos = 1'b0; start_is_train = 1'b0;
        ev_valid = 1'b0; ev_addr = '0; ev_last = 1'b0;
        process_done = 1'b0; goodness = '0; tmo_limit = 20'd1000;
        repeat (3) @(negedge clk);
        vectors++;
        if ({aerin_req, ev_ready, is_pos, is_train, busy, result_valid, result_is_pos, tmo_err} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 00000000",
                     {aerin_req, ev_ready, is_pos, is_train, busy, result_valid, result_is_pos, tmo_err});
        end
        vectors++;
        if (aerin_addr !== '0 || ev_count !== '0 || result_goodness !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got addr=%h cnt=%h good=%h want all 0", aerin_addr, ev_count, result_goodness);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || ev_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: got busy=%b ev_ready=%b want 0 0", busy, ev_ready);
        end
    endtask

    task automatic test_basic();
        logic [ADDR_W-1:0] a [16];
        bit ok, got;
        int cyc;
        logic [GOOD_W-1:0] g;
        logic p, e, second;
        a[0] = 12'h005; a[1] = 12'h123; a[2] = 12'h30F;
        for (int i = 3; i < 16; i++) a[i] = '0;
        seen_addr.delete();
        ack_dly = 2; tmo_limit = 20'd1000; goodness = 32'h0000_0ABC; process_done = 1'b0;
        do_start(1'b1, 1'b1);
        vectors++;
        if (is_pos !== 1'b1 || is_train !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_mode: got pos=%b train=%b busy=%b want 1 1 1", is_pos, is_train, busy);
        end
        send_events(3, a, 1'b0, ok);
        wait_hs(3, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL basic_handshake: got %0d events logged want 3", seen_addr.size());
        end
        repeat (10) @(negedge clk);
        process_done = 1'b1;
        get_result(60, got, cyc, g, p, e, second);
        process_done = 1'b0;
        vectors++;
        if (seen_addr.size() != 3) begin
            miscompares++;
            $display("FAIL basic_seq_len: got %0d want 3", seen_addr.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (seen_addr[i] !== a[i]) begin
                    miscompares++;
                    $display("FAIL basic_addr%0d: got %h want %h", i, seen_addr[i], a[i]);
                end
            end
        end
        vectors++;
        if (ev_count !== 16'd3) begin
            miscompares++;
            $display("FAIL basic_ev_count: got %0d want 3", ev_count);
        end
        vectors++;
        if (!got || second !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_pulse: got seen=%b second=%b want 1 0", got, second);
        end
        vectors++;
        if (g !== 32'h0000_0ABC || p !== 1'b1 || e !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_result: got good=%h pos=%b tmo=%b want 00000abc 1 0", g, p, e);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_busy_after: got %b want 0", busy);
        end
        exp_good = 32'h0000_0ABC;
        ack_dly = -1;
    endtask

    task automatic test_ack_stall();
        logic [ADDR_W-1:0] a [16];
        bit ok, got;
        int cyc, w;
        logic [GOOD_W-1:0] g;
        logic p, e, second;
        for (int i = 0; i < 16; i++) a[i] = '0;
        a[0] = 12'h0AA;
        seen_addr.delete();
        ack_stall = 1'b1;
        goodness = $urandom;
        do_start(1'b0, 1'b0);
        send_events(1, a, 1'b0, ok);
        w = 0;
        while (!aerin_req && w < 20) begin
            @(negedge clk);
            w++;
        end
        vectors++;
        if (aerin_req !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_req_rise: got %b want 1", aerin_req);
        end
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            vectors++;
            if (aerin_req !== 1'b1 || aerin_addr !== 12'h0AA || ev_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_hold c%0d: got req=%b addr=%h rdy=%b want 1 0aa 0",
                         c, aerin_req, aerin_addr, ev_ready);
            end
        end
        ack_stall = 1'b0;
        wait_hs(1, ok);
        process_done = 1'b1;
        get_result(60, got, cyc, g, p, e, second);
        process_done = 1'b0;
        vectors++;
        if (!got || g !== goodness || p !== 1'b0 || e !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_result: got seen=%b good=%h pos=%b tmo=%b want 1 %h 0 0", got, g, p, e, goodness);
        end
        if (got) exp_good = goodness;
    endtask

    task automatic run_timeout(input logic [TMO_W-1:0] lim, input string name);
        logic [ADDR_W-1:0] a [16];
        bit ok, got;
        int cyc;
        logic [GOOD_W-1:0] g;
        logic p, e, second;
        for (int i = 0; i < 16; i++) a[i] = 12'($urandom);
        seen_addr.delete();
        tmo_limit = lim;
        process_done = 1'b0;
        goodness = exp_good ^ 32'h5A5A_0001;
        do_start(1'b1, 1'b0);
        send_events(1, a, 1'b0, ok);
        wait_hs(1, ok);
        get_result(int'(lim) + 40, got, cyc, g, p, e, second);
        // ACK drop -> 2 sync flops -> leave REQ_LO -> lim+1 WAIT_DONE cycles -> RESULT.
        vectors++;
        if (!got || e !== 1'b1 || second !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_flag: got seen=%b tmo=%b second=%b want 1 1 0", name, got, e, second);
        end
        vectors++;
        if (g !== exp_good) begin
            miscompares++;
            $display("FAIL %s_retain: got %h want %h", name, g, exp_good);
        end
        vectors++;
        if (cyc < int'(lim) + 3 || cyc > int'(lim) + 5) begin
            miscompares++;
            $display("FAIL %s_latency: got %0d want %0d..%0d", name, cyc, int'(lim) + 3, int'(lim) + 5);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_busy_after: got %b want 0", name, busy);
        end
    endtask

    task automatic test_timeout();
        run_timeout(20'd100, "tmo100");
        run_timeout(20'd0, "tmo0");
    endtask

    task automatic test_done_tie();
        logic [ADDR_W-1:0] a [16];
        bit ok, got;
        int cyc;
        logic [GOOD_W-1:0] g;
        logic p, e, second;
        for (int i = 0; i < 16; i++) a[i] = 12'($urandom);
        seen_addr.delete();
        tmo_limit = 20'd0;
        goodness = ~exp_good;
        process_done = 1'b1;
        do_start(1'b1, 1'b1);
        send_events(1, a, 1'b0, ok);
        wait_hs(1, ok);
        get_result(40, got, cyc, g, p, e, second);
        process_done = 1'b0;
        vectors++;
        if (!got || g !== goodness || e !== 1'b0 || p !== 1'b1) begin
            miscompares++;
            $display("FAIL tie_done_wins: got seen=%b good=%h tmo=%b pos=%b want 1 %h 0 1", got, g, e, p, goodness);
        end
        if (got) exp_good = goodness;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_start_ignored();
        logic [ADDR_W-1:0] a [16];
        bit ok, got;
        int cyc;
        logic [GOOD_W-1:0] g;
        logic p, e, second;
        for (int i = 0; i < 16; i++) a[i] = 12'($urandom);
        seen_addr.delete();
        tmo_limit = 20'd1000;
        process_done = 1'b0;
        goodness = $urandom;
        do_start(1'b0, 1'b1);
        send_events(2, a, 1'b1, ok);
        wait_hs(2, ok);
        repeat (6) @(negedge clk);
        do_start(1'b1, 1'b0);
        @(negedge clk);
        vectors++;
        if (is_pos !== 1'b0 || is_train !== 1'b1 || ev_count !== 16'd2 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL start_ignored: got pos=%b train=%b cnt=%0d busy=%b want 0 1 2 1",
                     is_pos, is_train, ev_count, busy);
        end
        process_done = 1'b1;
        get_result(40, got, cyc, g, p, e, second);
        process_done = 1'b0;
        vectors++;
        if (!got || g !== goodness || p !== 1'b0 || e !== 1'b0) begin
            miscompares++;
            $display("FAIL start_ignored_result: got seen=%b good=%h pos=%b tmo=%b want 1 %h 0 0", got, g, p, e, goodness);
        end
        if (got) exp_good = goodness;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [ADDR_W-1:0] a [16];
        bit ok, got;
        int cyc, w;
        logic [GOOD_W-1:0] g;
        logic p, e, second;
        for (int i = 0; i < 16; i++) a[i] = 12'($urandom);
        seen_addr.delete();
        ack_stall = 1'b1;
        tmo_limit = 20'd1000;
        do_start(1'b1, 1'b1);
        send_events(1, a, 1'b0, ok);
        w = 0;
        while (!aerin_req && w < 20) begin
            @(negedge clk);
            w++;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({aerin_req, ev_ready, busy, is_pos, is_train, result_valid, tmo_err} !== 7'h00
            || aerin_addr !== '0 || ev_count !== '0 || result_goodness !== '0) begin
            miscompares++;
            $display("FAIL midreset_outputs: got req=%b busy=%b addr=%h cnt=%0d good=%h want all 0",
                     aerin_req, busy, aerin_addr, ev_count, result_goodness);
        end
        exp_good = '0;
        ack_stall = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        w = 0;
        while (aerin_ack && w < 20) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        vectors++;
        if (aerin_req !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_release: got req=%b busy=%b want 0 0", aerin_req, busy);
        end
        seen_addr.delete();
        goodness = $urandom;
        do_start(1'b0, 1'b1);
        send_events(1, a, 1'b0, ok);
        wait_hs(1, ok);
        process_done = 1'b1;
        get_result(40, got, cyc, g, p, e, second);
        process_done = 1'b0;
        vectors++;
        if (seen_addr.size() != 1 || seen_addr[0] !== a[0] || ev_count !== 16'd1) begin
            miscompares++;
            $display("FAIL midreset_rerun_seq: got n=%0d cnt=%0d want 1 event %h", seen_addr.size(), ev_count, a[0]);
        end
        vectors++;
        if (!got || g !== goodness || p !== 1'b0 || e !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_rerun_result: got seen=%b good=%h pos=%b tmo=%b want 1 %h 0 0", got, g, p, e, goodness);
        end
        if (got) exp_good = goodness;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] a [16];
        bit ok, got;
        int cyc, n;
        logic pos, train;
        logic [GOOD_W-1:0] g;
        logic p, e, second;
        for (int it = 0; it < 15; it++) begin
            n = $urandom_range(1, 6);
            for (int i = 0; i < 16; i++) a[i] = 12'($urandom);
            pos = 1'($urandom_range(0, 1));
            train = 1'($urandom_range(0, 1));
            goodness = $urandom;
            tmo_limit = 20'd1000;
            process_done = 1'b0;
            seen_addr.delete();
            do_start(pos, train);
            vectors++;
            if (is_pos !== pos || is_train !== train) begin
                miscompares++;
                $display("FAIL rnd%0d_mode: got %b%b want %b%b", it, is_pos, is_train, pos, train);
            end
            send_events(n, a, 1'b1, ok);
            wait_hs(n, ok);
            repeat ($urandom_range(0, 15)) @(negedge clk);
            process_done = 1'b1;
            get_result(60, got, cyc, g, p, e, second);
            process_done = 1'b0;
            vectors++;
            if (seen_addr.size() != n || ev_count !== 16'(n)) begin
                miscompares++;
                $display("FAIL rnd%0d_count: got logged=%0d cnt=%0d want %0d", it, seen_addr.size(), ev_count, n);
            end else begin
                for (int i = 0; i < n; i++) begin
                    vectors++;
                    if (seen_addr[i] !== a[i]) begin
                        miscompares++;
                        $display("FAIL rnd%0d_addr%0d: got %h want %h", it, i, seen_addr[i], a[i]);
                    end
                end
            end
            vectors++;
            if (!got || second !== 1'b0 || g !== goodness || p !== pos || e !== 1'b0) begin
                miscompares++;
                $display("FAIL rnd%0d_result: got seen=%b second=%b good=%h pos=%b tmo=%b want 1 0 %h %b 0",
                         it, got, second, g, p, e, goodness, pos);
            end
            if (got) exp_good = goodness;
            repeat (4) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ack_stall();
        test_timeout();
        test_done_tie();
        test_start_ignored();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
